// File: rtl/decode_pkg.sv
// Shared decode definitions: internal opcode ids, RV32 major opcodes and the decoded-entry payload.
package decode_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OPID_W = 7;
    localparam int unsigned IMM_W  = 32;
    localparam int unsigned RIDX_W = 5;

    typedef enum logic [OPID_W-1:0] {
        ID_ILLEGAL = 7'd0,
        ID_LUI     = 7'd1,  ID_AUIPC  = 7'd2,  ID_JAL    = 7'd3,  ID_JALR   = 7'd4,
        ID_BEQ     = 7'd5,  ID_BNE    = 7'd6,  ID_BLT    = 7'd7,  ID_BGE    = 7'd8,
        ID_BLTU    = 7'd9,  ID_BGEU   = 7'd10,
        ID_LB      = 7'd11, ID_LH     = 7'd12, ID_LW     = 7'd13, ID_LBU    = 7'd14,
        ID_LHU     = 7'd15,
        ID_SB      = 7'd16, ID_SH     = 7'd17, ID_SW     = 7'd18,
        ID_ADDI    = 7'd19, ID_SLTI   = 7'd20, ID_SLTIU  = 7'd21, ID_XORI   = 7'd22,
        ID_ORI     = 7'd23, ID_ANDI   = 7'd24,
        ID_SLLI    = 7'd25, ID_SRLI   = 7'd26, ID_SRAI   = 7'd27,
        ID_ADD     = 7'd28, ID_SUB    = 7'd29, ID_SLL    = 7'd30, ID_SLT    = 7'd31,
        ID_SLTU    = 7'd32, ID_XOR    = 7'd33, ID_SRL    = 7'd34, ID_SRA    = 7'd35,
        ID_OR      = 7'd36, ID_AND    = 7'd37,
        ID_MUL     = 7'd38, ID_MULH   = 7'd39, ID_MULHSU = 7'd40, ID_MULHU  = 7'd41,
        ID_DIV     = 7'd42, ID_DIVU   = 7'd43, ID_REM    = 7'd44, ID_REMU   = 7'd45
    } op_id_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        op_id_e              opcode;
        logic [RIDX_W-1:0]   rs1;
        logic [RIDX_W-1:0]   rs2;
        logic [RIDX_W-1:0]   rd;
        logic [IMM_W-1:0]    imm;
        logic                illegal;
    } dec_entry_t;

endpackage

// File: rtl/inst_decode_logic.sv
// Combinational RV32I word decoder. Define DECODE_RV32M_EN to also recognise the RV32M group.
module inst_decode_logic
    import decode_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output dec_entry_t        dec
);

    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             alt;
    logic [IMM_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    op_id_e           op;
    logic [IMM_W-1:0] imm;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign alt = inst[30];

    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    // Opcode id and immediate selection; anything unmatched stays illegal with a zero immediate.
    always_comb begin
        op  = ID_ILLEGAL;
        imm = '0;
        unique case (opc)
            OPC_LUI:   begin op = ID_LUI;   imm = imm_u; end
            OPC_AUIPC: begin op = ID_AUIPC; imm = imm_u; end
            OPC_JAL:   begin op = ID_JAL;   imm = imm_j; end
            OPC_JALR: begin
                if (f3 == 3'b000) op = ID_JALR;
                imm = imm_i;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000: op = ID_BEQ;
                    3'b001: op = ID_BNE;
                    3'b100: op = ID_BLT;
                    3'b101: op = ID_BGE;
                    3'b110: op = ID_BLTU;
                    3'b111: op = ID_BGEU;
                    default: op = ID_ILLEGAL;
                endcase
                imm = imm_b;
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000: op = ID_LB;
                    3'b001: op = ID_LH;
                    3'b010: op = ID_LW;
                    3'b100: op = ID_LBU;
                    3'b101: op = ID_LHU;
                    default: op = ID_ILLEGAL;
                endcase
                imm = imm_i;
            end
            OPC_STORE: begin
                case (f3)
                    3'b000: op = ID_SB;
                    3'b001: op = ID_SH;
                    3'b010: op = ID_SW;
                    default: op = ID_ILLEGAL;
                endcase
                imm = imm_s;
            end
            OPC_OP_IMM: begin
                imm = imm_i;
                case (f3)
                    3'b000: op = ID_ADDI;
                    3'b010: op = ID_SLTI;
                    3'b011: op = ID_SLTIU;
                    3'b100: op = ID_XORI;
                    3'b110: op = ID_ORI;
                    3'b111: op = ID_ANDI;
                    3'b001: begin op = ID_SLLI; imm = imm_sh; end
                    3'b101: begin op = alt ? ID_SRAI : ID_SRLI; imm = imm_sh; end
                    default: op = ID_ILLEGAL;
                endcase
            end
            OPC_OP: begin
                if (f7 == FUNCT7_MULDIV) begin
`ifdef DECODE_RV32M_EN
                    case (f3)
                        3'b000: op = ID_MUL;
                        3'b001: op = ID_MULH;
                        3'b010: op = ID_MULHSU;
                        3'b011: op = ID_MULHU;
                        3'b100: op = ID_DIV;
                        3'b101: op = ID_DIVU;
                        3'b110: op = ID_REM;
                        3'b111: op = ID_REMU;
                        default: op = ID_ILLEGAL;
                    endcase
`else
                    op = ID_ILLEGAL;
`endif
                end else begin
                    case (f3)
                        3'b000: op = alt ? ID_SUB : ID_ADD;
                        3'b001: op = ID_SLL;
                        3'b010: op = ID_SLT;
                        3'b011: op = ID_SLTU;
                        3'b100: op = ID_XOR;
                        3'b101: op = alt ? ID_SRA : ID_SRL;
                        3'b110: op = ID_OR;
                        3'b111: op = ID_AND;
                        default: op = ID_ILLEGAL;
                    endcase
                end
            end
            default: op = ID_ILLEGAL;
        endcase
    end

    // Register fields pass through for every encoding, illegal ones included.
    always_comb begin
        dec         = '0;
        dec.opcode  = op;
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.rd      = inst[11:7];
        dec.illegal = (op == ID_ILLEGAL);
        dec.imm     = (op == ID_ILLEGAL) ? '0 : imm;
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes IF words on the write side and buffers them in a circular FIFO toward DP.
// Optional RV32M decoding is enabled with DECODE_RV32M_EN.
module decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned REG_WIDTH   = 5,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  IFDC_en,
    input  logic [ADDR_WIDTH-1:0] IFDC_pc,
    input  logic [31:0]           IFDC_inst,
    input  logic                  IFDC_predict_result,
    output logic                  DCIF_stall,
    input  logic                  DPDC_stall,
    input  logic                  ROBDC_clear,
    output logic                  DCDP_en,
    output logic [ADDR_WIDTH-1:0] DCDP_pc,
    output logic [6:0]            DCDP_opcode,
    output logic [REG_WIDTH-1:0]  DCDP_rs1,
    output logic [REG_WIDTH-1:0]  DCDP_rs2,
    output logic [REG_WIDTH-1:0]  DCDP_rd,
    output logic [31:0]           DCDP_imm,
    output logic                  DCDP_predict_result,
    output logic                  DCDP_illegal
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    dec_entry_t            dec_in;
    dec_entry_t            dec_mem  [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
    logic                  pred_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full_c, push_c, pop_c;
    dec_entry_t            head_c;

    inst_decode_logic u_decode (
        .inst (IFDC_inst),
        .dec  (dec_in)
    );

    // Handshake: stall and pop derive from registered occupancy only.
    assign full_c = (count == CNT_W'(QUEUE_DEPTH));
    assign push_c = rdy_in & IFDC_en & ~full_c & ~ROBDC_clear;
    assign pop_c  = rdy_in & ~ROBDC_clear & (count != '0) & ~DPDC_stall;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                dec_mem[i]  <= '0;
                pc_mem[i]   <= '0;
                pred_mem[i] <= 1'b0;
            end
        end else if (ROBDC_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                dec_mem[wr_ptr]  <= dec_in;
                pc_mem[wr_ptr]   <= IFDC_pc;
                pred_mem[wr_ptr] <= IFDC_predict_result;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_c = dec_mem[rd_ptr];

    assign DCIF_stall          = full_c;
    assign DCDP_en             = pop_c;
    assign DCDP_pc             = pc_mem[rd_ptr];
    assign DCDP_opcode         = head_c.opcode;
    assign DCDP_rs1            = REG_WIDTH'(head_c.rs1);
    assign DCDP_rs2            = REG_WIDTH'(head_c.rs2);
    assign DCDP_rd             = REG_WIDTH'(head_c.rd);
    assign DCDP_imm            = head_c.imm;
    assign DCDP_predict_result = pred_mem[rd_ptr];
    assign DCDP_illegal        = head_c.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus random traffic against a queue-based model.
module tb_decode_queue;

`ifdef DECODE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk_in, rst_in, rdy_in, IFDC_en, IFDC_predict_result;
    logic [31:0] IFDC_pc, IFDC_inst;
    logic        DCIF_stall, DPDC_stall, ROBDC_clear, DCDP_en;
    logic [31:0] DCDP_pc, DCDP_imm;
    logic [6:0]  DCDP_opcode;
    logic [4:0]  DCDP_rs1, DCDP_rs2, DCDP_rd;
    logic        DCDP_predict_result, DCDP_illegal;

    decode_queue dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .IFDC_en             (IFDC_en),
        .IFDC_pc             (IFDC_pc),
        .IFDC_inst           (IFDC_inst),
        .IFDC_predict_result (IFDC_predict_result),
        .DCIF_stall          (DCIF_stall),
        .DPDC_stall          (DPDC_stall),
        .ROBDC_clear         (ROBDC_clear),
        .DCDP_en             (DCDP_en),
        .DCDP_pc             (DCDP_pc),
        .DCDP_opcode         (DCDP_opcode),
        .DCDP_rs1            (DCDP_rs1),
        .DCDP_rs2            (DCDP_rs2),
        .DCDP_rd             (DCDP_rd),
        .DCDP_imm            (DCDP_imm),
        .DCDP_predict_result (DCDP_predict_result),
        .DCDP_illegal        (DCDP_illegal)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        int          opc;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        pred;
        logic        ill;
    } exp_t;

    exp_t        model_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          drops    = 0;
    logic [31:0] pc_ctr   = 32'h0000_1000;

    // Opcode id lookup by funct3, straight from the opcode id list.
    int br_tbl [8] = '{5, 6, 0, 0, 7, 8, 9, 10};
    int ld_tbl [8] = '{11, 12, 13, 0, 14, 15, 0, 0};
    int st_tbl [8] = '{16, 17, 18, 0, 0, 0, 0, 0};
    int oi_tbl [8] = '{19, 25, 20, 21, 22, 26, 23, 24};
    int op_tbl [8] = '{28, 30, 31, 32, 33, 34, 36, 37};
    logic [6:0] majors [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7B};

    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
        exp_t               e;
        logic signed [31:0] s;
        int                 f3;
        longint             off;
        s      = inst;
        f3     = int'(inst[14:12]);
        e.pc   = pc;
        e.pred = pred;
        e.rs1  = inst[19:15];
        e.rs2  = inst[24:20];
        e.rd   = inst[11:7];
        e.opc  = 0;
        e.imm  = 32'h0;
        case (inst[6:0])
            7'h37: begin e.opc = 1; e.imm = inst & 32'hFFFF_F000; end
            7'h17: begin e.opc = 2; e.imm = inst & 32'hFFFF_F000; end
            7'h6F: begin
                e.opc = 3;
                off = longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
                if (inst[31]) off = off - (64'sd1 << 21);
                e.imm = 32'(off);
            end
            7'h67: begin e.opc = (f3 == 0) ? 4 : 0; e.imm = 32'(s >>> 20); end
            7'h63: begin
                e.opc = br_tbl[f3];
                off = longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
                if (inst[31]) off = off - (64'sd1 << 13);
                e.imm = 32'(off);
            end
            7'h03: begin e.opc = ld_tbl[f3]; e.imm = 32'(s >>> 20); end
            7'h23: begin e.opc = st_tbl[f3]; e.imm = 32'((s >>> 25) <<< 5) | 32'(inst[11:7]); end
            7'h13: begin
                e.opc = oi_tbl[f3] + ((f3 == 5 && inst[30]) ? 1 : 0);
                e.imm = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : 32'(s >>> 20);
            end
            7'h33: begin
                if (inst[31:25] == 7'd1) e.opc = M_EN ? 38 + f3 : 0;
                else e.opc = op_tbl[f3] + (((f3 == 0 || f3 == 5) && inst[30]) ? 1 : 0);
            end
            default: e.opc = 0;
        endcase
        e.ill = (e.opc == 0);
        if (e.ill) e.imm = 32'h0;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w      = $urandom;
        w[6:0] = majors[$urandom_range(0, 9)];
        if (w[6:0] == 7'h33) begin
            if ($urandom_range(0, 2) == 0) w[31:25] = 7'd1;
            else w[31:25] = {1'b0, w[30], 5'b0};
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input exp_t e);
        chk("head_pc",   DCDP_pc, e.pc);
        chk("head_opc",  32'(DCDP_opcode), 32'(e.opc));
        chk("head_rs1",  32'(DCDP_rs1), 32'(e.rs1));
        chk("head_rs2",  32'(DCDP_rs2), 32'(e.rs2));
        chk("head_rd",   32'(DCDP_rd), 32'(e.rd));
        chk("head_imm",  DCDP_imm, e.imm);
        chk("head_pred", 32'(DCDP_predict_result), 32'(e.pred));
        chk("head_ill",  32'(DCDP_illegal), 32'(e.ill));
    endtask

    // One clock: drive at negedge, check pre-edge outputs, then advance the model across the edge.
    task automatic step(input logic rst, input logic rdy, input logic en, input logic [31:0] inst,
                        input logic pred, input logic dps, input logic clr);
        logic exp_en, full;
        @(negedge clk_in);
        rst_in = rst; rdy_in = rdy; IFDC_en = en; IFDC_pc = pc_ctr; IFDC_inst = inst;
        IFDC_predict_result = pred; DPDC_stall = dps; ROBDC_clear = clr;
        #1;
        full   = (model_q.size() == DEPTH);
        exp_en = rdy && !clr && (model_q.size() != 0) && !dps;
        chk("dcdp_en", 32'(DCDP_en), 32'(exp_en));
        chk("dcif_stall", 32'(DCIF_stall), 32'(full));
        if (model_q.size() != 0) chk_head(model_q[0]);
        if (rst) model_q.delete();
        else if (clr) model_q.delete();
        else if (rdy) begin
            if (exp_en) void'(model_q.pop_front());
            if (en && full) begin
                drops++;
                $display("note: IFDC_en asserted while stalled, entry dropped (protocol violation)");
            end else if (en) model_q.push_back(ref_decode(pc_ctr, inst, pred));
        end
        pc_ctr = pc_ctr + 32'd4;
        @(posedge clk_in);
    endtask

    task automatic push(input logic dps);
        step(1'b0, 1'b1, 1'b1, rand_inst(), 1'($urandom_range(0, 1)), dps, 1'b0);
    endtask

    task automatic idle(input logic dps);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, dps, 1'b0);
    endtask

    task automatic check_zero();
        @(negedge clk_in);
        rst_in = 1'b0; rdy_in = 1'b1; IFDC_en = 1'b0; DPDC_stall = 1'b0; ROBDC_clear = 1'b0;
        #1;
        chk("rst_en", 32'(DCDP_en), 32'h0);
        chk("rst_stall", 32'(DCIF_stall), 32'h0);
        chk("rst_pc", DCDP_pc, 32'h0);
        chk("rst_opc", 32'(DCDP_opcode), 32'h0);
        chk("rst_regs", 32'({DCDP_rs1, DCDP_rs2, DCDP_rd}), 32'h0);
        chk("rst_imm", DCDP_imm, 32'h0);
        chk("rst_flags", 32'({DCDP_predict_result, DCDP_illegal}), 32'h0);
    endtask

    task automatic push_expect(input logic [31:0] inst, input int opc, input logic [31:0] imm);
        step(1'b0, 1'b1, 1'b1, inst, 1'b0, 1'b0, 1'b0);
        #2;
        chk("sweep_opc", 32'(DCDP_opcode), 32'(opc));
        chk("sweep_imm", DCDP_imm, imm);
        chk("sweep_ill", 32'(DCDP_illegal), 32'(opc == 0));
        idle(1'b0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; IFDC_en = 1'b0; IFDC_pc = 32'h0; IFDC_inst = 32'h0;
        IFDC_predict_result = 1'b0; DPDC_stall = 1'b0; ROBDC_clear = 1'b0;
        repeat (2) @(posedge clk_in);
        check_zero();

        // Decode sweep
        push_expect(32'h0050_0093, 19, 32'h0000_0005);
        push_expect(32'hFE00_0EE3, 5,  32'hFFFF_FFFC);
        push_expect(32'h8000_00B7, 1,  32'h8000_0000);
        push_expect(32'h4020_8133, 29, 32'h0000_0000);
        push_expect(32'h0220_8033, M_EN ? 38 : 0, 32'h0000_0000);

        // Fill to full under DP backpressure, one refused push, then drain in order
        repeat (4) push(1'b1);
        push(1'b1);
        repeat (5) idle(1'b0);

        // Simultaneous push/pop at occupancy 2 across pointer wrap
        repeat (2) push(1'b1);
        repeat (12) push(1'b0);
        repeat (3) idle(1'b0);

        // Flush with three entries and a concurrent push
        repeat (3) push(1'b1);
        step(1'b0, 1'b1, 1'b1, rand_inst(), 1'b1, 1'b0, 1'b1);
        idle(1'b0);

        // Global pause mid-stream
        repeat (2) push(1'b1);
        push(1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        // Reset mid-stream
        repeat (3) push(1'b1);
        step(1'b1, 1'b1, 1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
        check_zero();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r_rst, r_rdy, r_en, r_dps, r_clr;
            r_rst = ($urandom_range(0, 99) == 0);
            r_clr = ($urandom_range(0, 99) < 5);
            r_rdy = ($urandom_range(0, 99) < 85);
            r_dps = ($urandom_range(0, 99) < 40);
            r_en  = ($urandom_range(0, 99) < 60);
            if (model_q.size() == DEPTH && $urandom_range(0, 4) != 0) r_en = 1'b0;
            step(r_rst, r_rdy, r_en, rand_inst(), 1'($urandom_range(0, 1)), r_dps, r_clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
